// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU sequencer and its ALU: opcodes, FSM states and
// helpers that locate the fields of an instruction word.
package mcpu_pkg;

   localparam logic [1:0] CMD_AND = 2'b00;
   localparam logic [1:0] CMD_OR  = 2'b01;
   localparam logic [1:0] CMD_XOR = 2'b10;
   localparam logic [1:0] CMD_ADD = 2'b11;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB} state_t;

   // Word layout, MSB first: {I, opcode, rd, rs1, rs2}
   function automatic int f_iw(input int cmd_size, input int reg_addr);
      return 1 + cmd_size + 3*reg_addr;
   endfunction

   function automatic int f_rd_lsb(input int reg_addr);
      return 2*reg_addr;
   endfunction

   function automatic int f_rs1_lsb(input int reg_addr);
      return reg_addr;
   endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// Small register file: two operand read ports, one debug read port, one write port.
module mcpu_regfile #(
   parameter int WORD_SIZE = 8,
   parameter int REG_ADDR  = 2
) (
   input  logic                 i_clk,
   input  logic                 i_resetn,
   input  logic                 i_we,
   input  logic [REG_ADDR-1:0]  i_waddr,
   input  logic [WORD_SIZE-1:0] i_wdata,
   input  logic [REG_ADDR-1:0]  i_raddr1,
   output logic [WORD_SIZE-1:0] o_rdata1,
   input  logic [REG_ADDR-1:0]  i_raddr2,
   output logic [WORD_SIZE-1:0] o_rdata2,
   input  logic [REG_ADDR-1:0]  i_dbg_raddr,
   output logic [WORD_SIZE-1:0] o_dbg_rdata
);

   localparam int NREG = 2**REG_ADDR;

   logic [NREG-1:0][WORD_SIZE-1:0] r_mem;

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn)
         r_mem <= '0;
      else if (i_we)
         r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata1    = r_mem[i_raddr1];
   assign o_rdata2    = r_mem[i_raddr2];
   assign o_dbg_rdata = r_mem[i_dbg_raddr];

endmodule

// File: rtl/mcpu_seq.sv
// Multi-cycle fetch/decode/execute/writeback sequencer feeding a combinational ALU.
// ALU operands are registered in DECODE; the ALU result is captured in EXEC.
module mcpu_seq
   import mcpu_pkg::*;
#(
   parameter int CMD_SIZE  = 2,
   parameter int WORD_SIZE = 8,
   parameter int REG_ADDR  = 2,
   parameter int PC_SIZE   = 8,
   localparam int IW       = f_iw(CMD_SIZE, REG_ADDR)
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 run,
   output logic                 imem_req,
   output logic [PC_SIZE-1:0]   imem_addr,
   input  logic                 imem_ack,
   input  logic [IW-1:0]        imem_data,
   output logic [CMD_SIZE-1:0]  alu_opcode,
   output logic [WORD_SIZE-1:0] alu_r1,
   output logic [WORD_SIZE-1:0] alu_r2,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic                 alu_ovf,
   output logic [PC_SIZE-1:0]   pc,
   output logic                 ovf_flag,
   output logic                 busy,
   input  logic [REG_ADDR-1:0]  dbg_raddr,
   output logic [WORD_SIZE-1:0] dbg_rdata
);

   state_t                r_state;
   logic [IW-1:0]         r_ir;
   logic [WORD_SIZE-1:0]  r_res;
   logic                  r_res_ovf;
   logic [PC_SIZE-1:0]    r_pc;
   logic                  r_ovf;
   logic                  r_req;
   logic [CMD_SIZE-1:0]   r_opcode;
   logic [WORD_SIZE-1:0]  r_r1;
   logic [WORD_SIZE-1:0]  r_r2;

   logic                  w_imm_f;
   logic [CMD_SIZE-1:0]   w_op;
   logic [REG_ADDR-1:0]   w_rd;
   logic [REG_ADDR-1:0]   w_rs1;
   logic [REG_ADDR-1:0]   w_rs2;
   logic [WORD_SIZE-1:0]  w_imm;
   logic [WORD_SIZE-1:0]  w_rd1;
   logic [WORD_SIZE-1:0]  w_rd2;
   logic                  w_we;
   logic [WORD_SIZE-1:0]  w_wdata;

   assign w_imm_f = r_ir[IW-1];
   assign w_op    = r_ir[IW-2 -: CMD_SIZE];
   assign w_rd    = r_ir[f_rd_lsb(REG_ADDR)  +: REG_ADDR];
   assign w_rs1   = r_ir[f_rs1_lsb(REG_ADDR) +: REG_ADDR];
   assign w_rs2   = r_ir[0 +: REG_ADDR];
   assign w_imm   = {{(WORD_SIZE-2*REG_ADDR){1'b0}}, w_rs1, w_rs2};
   assign w_we    = (r_state == WB);
   assign w_wdata = w_imm_f ? w_imm : r_res;

   mcpu_regfile #(.WORD_SIZE(WORD_SIZE), .REG_ADDR(REG_ADDR)) u_rf (
      .i_clk       (clk),
      .i_resetn    (resetn),
      .i_we        (w_we),
      .i_waddr     (w_rd),
      .i_wdata     (w_wdata),
      .i_raddr1    (w_rs1),
      .o_rdata1    (w_rd1),
      .i_raddr2    (w_rs2),
      .o_rdata2    (w_rd2),
      .i_dbg_raddr (dbg_raddr),
      .o_dbg_rdata (dbg_rdata)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= IDLE;
         r_ir      <= '0;
         r_res     <= '0;
         r_res_ovf <= 1'b0;
         r_pc      <= '0;
         r_ovf     <= 1'b0;
         r_req     <= 1'b0;
         r_opcode  <= '0;
         r_r1      <= '0;
         r_r2      <= '0;
      end else begin
         case (r_state)
            IDLE: if (run) begin
               r_state <= FETCH;
               r_req   <= 1'b1;
            end
            FETCH: if (imem_ack) begin
               r_ir    <= imem_data;
               r_req   <= 1'b0;
               r_state <= DECODE;
            end
            DECODE: begin
               // Immediates skip the ALU entirely and leave alu_* untouched
               if (w_imm_f) begin
                  r_state <= WB;
               end else begin
                  r_opcode <= w_op;
                  r_r1     <= w_rd1;
                  r_r2     <= w_rd2;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               r_res     <= alu_out;
               r_res_ovf <= alu_ovf;
               r_state   <= WB;
            end
            WB: begin
               if (!w_imm_f && (w_op == CMD_SIZE'(CMD_ADD)) && r_res_ovf)
                  r_ovf <= 1'b1;
               r_pc <= r_pc + PC_SIZE'(1);
               if (run) begin
                  r_state <= FETCH;
                  r_req   <= 1'b1;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign imem_req   = r_req;
   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign ovf_flag   = r_ovf;
   assign alu_opcode = r_opcode;
   assign alu_r1     = r_r1;
   assign alu_r2     = r_r2;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mcpu_seq.sv
// Bench for mcpu_seq: stand-in ALU, an instruction-level reference model with
// cycle-scheduled visibility, and a per-cycle compare process.
module tb_mcpu_seq;
   import mcpu_pkg::*;

   logic       clk = 1'b0;
   logic       resetn, run, imem_ack;
   logic [8:0] imem_data;
   logic       imem_req, ovf_flag, busy;
   logic [7:0] imem_addr, pc, alu_r1, alu_r2, dbg_rdata;
   logic [1:0] alu_opcode;
   logic [7:0] alu_out;
   logic       alu_ovf;
   logic [1:0] dbg_raddr = 2'd0;
   logic [8:0] alu_sum;

   always #5 clk = ~clk;

   mcpu_seq dut (
      .clk(clk), .resetn(resetn), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .alu_opcode(alu_opcode), .alu_r1(alu_r1), .alu_r2(alu_r2),
      .alu_out(alu_out), .alu_ovf(alu_ovf),
      .pc(pc), .ovf_flag(ovf_flag), .busy(busy),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   // Stand-in for MCPU_Alu: overflow is the unsigned carry of ADD
   always_comb begin
      alu_sum = {1'b0, alu_r1} + {1'b0, alu_r2};
      alu_out = 8'h00;
      alu_ovf = 1'b0;
      case (alu_opcode)
         CMD_AND: alu_out = alu_r1 & alu_r2;
         CMD_OR:  alu_out = alu_r1 | alu_r2;
         CMD_XOR: alu_out = alu_r1 ^ alu_r2;
         default: begin alu_out = alu_sum[7:0]; alu_ovf = alu_sum[8]; end
      endcase
   end

   int n_pass = 0, n_tot = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Architectural model state plus one in-flight instruction
   logic [7:0] e_reg [4];
   logic [7:0] e_pc = 8'd0, e_r1 = 8'd0, e_r2 = 8'd0;
   logic [1:0] e_op = 2'd0;
   logic       e_ovf = 1'b0;
   bit         p_valid = 1'b0, p_isalu, p_ovf;
   int         p_alu_cyc, p_com_cyc;
   logic [1:0] p_op, p_rd;
   logic [7:0] p_r1, p_r2, p_wdata;
   bit         dbg_force = 1'b0;
   logic [1:0] dbg_sel = 2'd0;

   initial for (int i = 0; i < 4; i++) e_reg[i] = 8'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) e_reg[i] = 8'd0;
      e_pc = 8'd0; e_ovf = 1'b0; e_op = 2'd0; e_r1 = 8'd0; e_r2 = 8'd0;
      p_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (p_valid && p_isalu && cyc == p_alu_cyc) begin
         e_op = p_op; e_r1 = p_r1; e_r2 = p_r2;
      end
      if (p_valid && cyc == p_com_cyc) begin
         e_reg[p_rd] = p_wdata;
         e_ovf = e_ovf | p_ovf;
         e_pc = e_pc + 8'd1;
         p_valid = 1'b0;
      end
      chk("pc", pc, e_pc);
      chk("imem_addr", imem_addr, e_pc);
      chk("ovf_flag", ovf_flag, e_ovf);
      chk("alu_opcode", alu_opcode, e_op);
      chk("alu_r1", alu_r1, e_r1);
      chk("alu_r2", alu_r2, e_r2);
      chk("dbg_rdata", dbg_rdata, e_reg[dbg_raddr]);
      dbg_raddr = dbg_force ? dbg_sel : 2'($urandom);
   end

   function automatic logic [8:0] mk_imm(input logic [1:0] rd, input logic [3:0] v);
      return {1'b1, 2'b00, rd, v};
   endfunction

   function automatic logic [8:0] mk_alu(input logic [1:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
      return {1'b0, op, rd, rs1, rs2};
   endfunction

   task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string nm);
      dbg_force = 1'b1; dbg_sel = a;
      @(negedge clk); #1;
      chk(nm, dbg_rdata, exp);
      dbg_force = 1'b0;
   endtask

   // Serve one fetch: stall dly cycles, ack, schedule the model's effects
   task automatic fetch(input logic [8:0] w, input int dly, input bit drop,
                        input bit spur, input bit rst);
      int t, c;
      bit isimm;
      logic [7:0] a, b;
      logic [8:0] s;
      t = 0;
      while (imem_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      if (imem_req !== 1'b1) begin chk("fetch_timeout", imem_req, 1); return; end
      for (int i = 0; i < dly; i++) begin
         chk("stall_req", imem_req, 1);
         chk("stall_addr", imem_addr, e_pc);
         imem_data = 9'($urandom);
         @(negedge clk);
      end
      c = cyc;
      isimm = w[8];
      a = e_reg[w[3:2]]; b = e_reg[w[1:0]]; s = {1'b0, a} + {1'b0, b};
      p_isalu = !isimm; p_op = w[7:6]; p_rd = w[5:4]; p_r1 = a; p_r2 = b; p_ovf = 1'b0;
      p_alu_cyc = c + 2;
      p_com_cyc = isimm ? c + 3 : c + 4;
      if (isimm) p_wdata = {4'h0, w[3:0]};
      else case (w[7:6])
         2'b00: p_wdata = a & b;
         2'b01: p_wdata = a | b;
         2'b10: p_wdata = a ^ b;
         default: begin p_wdata = s[7:0]; p_ovf = s[8]; end
      endcase
      p_valid = 1'b1;
      imem_ack = 1'b1; imem_data = w;
      @(posedge clk); #1;
      imem_ack = 1'b0; imem_data = 9'($urandom);
      @(negedge clk);
      chk("req_drop", imem_req, 0);
      chk("busy_mid", busy, 1);
      if (drop) run = 1'b0;
      if (!isimm) begin
         @(negedge clk);
         chk("alu_op_exec", alu_opcode, w[7:6]);
         if (rst) begin
            #2 resetn = 1'b0;
            model_clear();
            run = 1'b0;
            #1;
            chk("rst_pc", pc, 0);       chk("rst_busy", busy, 0);
            chk("rst_req", imem_req, 0); chk("rst_ovf", ovf_flag, 0);
            chk("rst_op", alu_opcode, 0); chk("rst_r1", alu_r1, 0);
            chk("rst_r2", alu_r2, 0);
            @(negedge clk); #2 resetn = 1'b1;
            return;
         end
         if (spur) begin
            imem_ack = 1'b1; imem_data = 9'($urandom);
            @(posedge clk); #1 imem_ack = 1'b0;
         end
      end
      while (cyc < p_com_cyc) @(negedge clk);
      #1;
      if (drop) begin
         chk("idle_busy", busy, 0);
         chk("idle_req", imem_req, 0);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_tot);
      $fatal(1);
   end

   initial begin
      resetn = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = 9'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_pc", pc, 0); chk("reset_busy", busy, 0); chk("reset_req", imem_req, 0);
      chk("reset_ovf", ovf_flag, 0); chk("reset_alu_r1", alu_r1, 0);
      resetn = 1'b1;

      // Immediates r0=9, r1=5
      run = 1'b1;
      fetch(mk_imm(2'd0, 4'd9), 0, 0, 0, 0);
      fetch(mk_imm(2'd1, 4'd5), 0, 1, 0, 0);
      chk("pc_after_imm", pc, 2);
      peek(2'd0, 8'd9, "r0_imm");
      peek(2'd1, 8'd5, "r1_imm");

      // Logic ops into r2
      run = 1'b1; fetch(mk_alu(CMD_AND, 2'd2, 2'd0, 2'd1), 0, 1, 0, 0); peek(2'd2, 8'd1,  "and_9_5");
      run = 1'b1; fetch(mk_alu(CMD_OR,  2'd2, 2'd0, 2'd1), 0, 1, 0, 0); peek(2'd2, 8'd13, "or_9_5");
      run = 1'b1; fetch(mk_alu(CMD_XOR, 2'd2, 2'd0, 2'd1), 0, 1, 0, 0); peek(2'd2, 8'd12, "xor_9_5");
      chk("ovf_after_logic", ovf_flag, 0);

      // Build 0xFF in r0, then 0xFF + 2 overflows
      run = 1'b1;
      fetch(mk_imm(2'd0, 4'hF), 0, 0, 0, 0);
      fetch(mk_alu(CMD_ADD, 2'd1, 2'd0, 2'd0), 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) fetch(mk_alu(CMD_ADD, 2'd1, 2'd1, 2'd1), 0, 0, 0, 0);
      fetch(mk_alu(CMD_OR, 2'd0, 2'd1, 2'd0), 0, 0, 0, 0);
      fetch(mk_imm(2'd1, 4'd2), 0, 0, 0, 0);
      chk("ovf_before_add", ovf_flag, 0);
      fetch(mk_alu(CMD_ADD, 2'd3, 2'd0, 2'd1), 0, 0, 0, 0);
      chk("ovf_set", ovf_flag, 1);
      fetch(mk_imm(2'd0, 4'd1), 0, 0, 0, 0);
      fetch(mk_alu(CMD_ADD, 2'd2, 2'd0, 2'd0), 0, 1, 0, 0);
      peek(2'd3, 8'h01, "add_ff_02");
      peek(2'd2, 8'h02, "add_1_1");
      chk("ovf_sticky", ovf_flag, 1);

      // Stalled fetch, then a spurious ack during EXEC
      run = 1'b1;
      fetch(mk_imm(2'd1, 4'd7), 5, 0, 0, 0);
      fetch(mk_alu(CMD_XOR, 2'd2, 2'd1, 2'd3), 0, 1, 1, 0);
      peek(2'd1, 8'd7, "stall_imm");
      peek(2'd2, 8'd6, "xor_7_1");

      // Random instructions with random stalls
      run = 1'b1;
      for (int i = 0; i < 40; i++)
         fetch(9'($urandom), int'($urandom_range(0, 3)), (i == 39), 1'($urandom_range(0, 1)), 0);

      // Reset during EXEC aborts the write
      run = 1'b1;
      fetch(mk_alu(CMD_OR, 2'd3, 2'd1, 2'd2), 0, 0, 0, 1);
      peek(2'd3, 8'd0, "rst_exec_rd");
      chk("rst_exec_busy", busy, 0);

      // Walk pc up to 255 and wrap
      run = 1'b1;
      for (int i = 0; i < 300 && e_pc != 8'hFF; i++)
         fetch(mk_imm(2'($urandom), 4'($urandom)), 0, 0, 0, 0);
      chk("pc_at_255", pc, 8'hFF);
      fetch(mk_imm(2'd0, 4'd3), 0, 1, 0, 0);
      chk("pc_wrap", pc, 0);
      chk("addr_wrap", imem_addr, 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/mcpu_seq.md
Name: mcpu_seq

Overview:
- Multi-cycle sequencer directly upstream of MCPU_Alu.
- Fetches instruction words from an external instruction memory over a req/ack handshake and decodes them.
- Reads a small internal register file, drives the ALU operand/opcode inputs, and writes the ALU result (or an immediate) back.
- Tracks a sticky overflow flag from ADD results; the ALU itself stays purely combinational.

Parameters:
- CMD_SIZE, 2, ALU opcode width; must match MCPU_Alu.
- WORD_SIZE, 8, data/register width; must match MCPU_Alu.
- REG_ADDR, 2, register address width (2**REG_ADDR registers).
- PC_SIZE, 8, program counter / instruction address width.
- IW (derived localparam), 1+CMD_SIZE+3*REG_ADDR (= 9), instruction width.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- run  in  1  level; sequencer fetches only while high
- imem_req  out  1  fetch request
- imem_addr  out  PC_SIZE  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  IW  instruction word
- alu_opcode  out  CMD_SIZE  to ALU opcode
- alu_r1  out  WORD_SIZE  to ALU r1
- alu_r2  out  WORD_SIZE  to ALU r2
- alu_out  in  WORD_SIZE  from ALU out
- alu_ovf  in  1  from ALU OVERFLOW
- pc  out  PC_SIZE  current program counter
- ovf_flag  out  1  sticky ADD overflow
- busy  out  1  high in any state other than IDLE
- dbg_raddr  in  REG_ADDR  debug register read address
- dbg_rdata  out  WORD_SIZE  combinational read of regfile[dbg_raddr]

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - pc, all registers, alu_opcode, alu_r1, alu_r2, ovf_flag and imem_req all clear to 0; busy=0.
  - Reset asserted in any state, including mid-fetch, aborts the instruction with no writeback.
- Instruction fields, MSB to LSB:
  - I flag [IW-1]
  - opcode [IW-2 -: CMD_SIZE]
  - rd
  - rs1
  - rs2
- Immediate form (I=1): imm = {rs1,rs2}, zero-extended to WORD_SIZE; opcode field ignored.
- Opcodes: 00 AND, 01 OR, 10 XOR, 11 ADD.
- States:
  - IDLE: if run=1, go to FETCH.
  - FETCH: imem_req=1 and imem_addr=pc. On imem_ack=1, latch imem_data into the instruction register and go to DECODE. imem_req drops on the next edge. Otherwise stay in FETCH; no timeout.
  - DECODE: I=1 goes to WB. Otherwise register alu_opcode=opcode, alu_r1=reg[rs1], alu_r2=reg[rs2], and go to EXEC.
  - EXEC: one settle cycle; capture alu_out and alu_ovf into a result register; go to WB.
  - WB:
    - Write reg[rd] with imm (I=1) or the captured result.
    - If the instruction was ADD and the captured ovf=1, set ovf_flag.
    - pc <= pc+1, wrapping from 2**PC_SIZE-1 to 0.
    - Go to FETCH if run=1, else IDLE.
- Latency with imem_ack in the first FETCH cycle:
  - ALU instruction: 4 cycles, FETCH to WB inclusive.
  - Immediate instruction: 3 cycles.
- run is sampled only in IDLE and WB. Deasserting run mid-instruction completes that instruction.
- imem_ack outside FETCH is ignored.
- alu_* outputs hold their last values between instructions; immediate instructions do not change them.
- ovf_flag is cleared only by reset; it is not cleared by non-overflowing ADDs or by other opcodes.
- rd may equal rs1/rs2: operands are read in DECODE and the write happens in WB, so the old value is used.
- dbg_rdata reflects a write on the cycle after WB.

Decomposition:
- Package mcpu_pkg:
  - opcode constants CMD_AND/CMD_OR/CMD_XOR/CMD_ADD, shared with MCPU_Alu and its bench
  - state enum (IDLE, FETCH, DECODE, EXEC, WB)
  - field-offset helpers for the instruction word
- One sub-module, mcpu_regfile:
  - 2**REG_ADDR x WORD_SIZE
  - two combinational read ports plus the debug read port
  - one synchronous write port
  - async active-low clear

Test Plan:
- Immediates: imem returns I=1 words loading r0=9, r1=5, ack same cycle, run=1 -> each instruction takes 3 cycles; dbg_rdata r0=9, r1=5; pc=2.
- ALU ops:
  - Given r0=9, r1=5: AND r2=r0,r1 -> 1; OR -> 13; XOR -> 12.
  - Each: alu_opcode seen in EXEC, 4 cycles per instruction, ovf_flag=0.
- Overflow: with a real MCPU_Alu instance, preload r0=0xFF, r1=0x02, then ADD r3=r0,r1 -> r3=0x01, ovf_flag=1. A later ADD 1+1=2 leaves ovf_flag=1.
- Fetch stall: ack delayed 5 cycles -> imem_req held 6 cycles with a stable imem_addr; data is latched only on the ack cycle; a spurious ack while in EXEC has no effect.
- Run/reset: run dropped during DECODE -> instruction completes, then IDLE with busy=0. resetn pulsed low during EXEC -> all outputs 0 immediately; rd unchanged (0).
- Wrap: pc preloaded to 255 via 255 immediate fetches -> after the next WB pc=0 and imem_addr=0.
